barcode_scan_ctrl: RTL and testbench

- Frame-level sequencer for the threshold barcode scanner (EAN-13, 13 BCD digits).
- Each frame: samples the scanner result and steers the scanner's sampling row.
- Requires N identical consecutive decodes, then validates the checksum.
- Publishes a confirmed code once over a valid/ready handshake to the UART/LCD formatter.

---
 rtl/barcode_pkg.sv | 21 ++
 rtl/ean13_cksum.sv | 27 ++
 rtl/barcode_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_barcode_scan_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/barcode_pkg.sv
// Shared types and constants for the EAN-13 barcode scan controller.
// A code is 13 BCD digits; digit k occupies bits [4k+3:4k], digit 0 is printed first.
package barcode_pkg;

  localparam int N_DIGITS = 13;
  localparam int N_ROWS   = 4;

  typedef logic [3:0]              digit_t;
  typedef digit_t [N_DIGITS-1:0]   code_t;

  // True when every digit of the code is a legal BCD value (0..9).
  function automatic logic digits_valid(input code_t c);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      ok = ok && (c[k] <= 4'd9);
    end
    return ok;
  endfunction

endpackage

// File: rtl/ean13_cksum.sv
// Combinational EAN-13 check-digit test.
// Weights digits 0,2,..,10 by 1 and 1,3,..,11 by 3, adds the check digit (12);
// the code passes when the total is a multiple of ten.
module ean13_cksum
  import barcode_pkg::*;
(
  input  code_t code,
  output logic  pass
);

  logic [5:0] odd_s;
  logic [5:0] even_s;
  logic [7:0] total_s;

  // Sum the two digit groups and test the weighted total modulo ten.
  always_comb begin
    odd_s  = 6'd0;
    even_s = 6'd0;
    for (int k = 0; k < 6; k++) begin
      odd_s  = odd_s  + {2'b00, code[2*k]};
      even_s = even_s + {2'b00, code[2*k+1]};
    end
    total_s = {2'b00, odd_s} + ({2'b00, even_s} * 8'd3) + {4'b0000, code[12]};
    pass    = ((total_s % 8'd10) == 8'd0);
  end

endmodule

// File: rtl/barcode_scan_ctrl.sv
// Frame-level sequencer for the threshold barcode scanner.
// Samples the scanner once per frame, confirms a code after CONFIRM_N identical
// good decodes, publishes it once over valid/ready, and rotates the scan row
// after MISS_LIMIT consecutive failed frames.
// Optional build macro: BARCODE_CKSUM_EN adds the EAN-13 checksum to the good test.
module barcode_scan_ctrl
  import barcode_pkg::*;
#(
  parameter logic [9:0] ROW0       = 10'd80,
  parameter logic [9:0] ROW1       = 10'd100,
  parameter logic [9:0] ROW2       = 10'd130,
  parameter logic [9:0] ROW3       = 10'd160,
  parameter int         MISS_LIMIT = 4,
  parameter int         CONFIRM_N  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_sync,
  input  logic       scan_en,
  input  code_t      scan_data,
  output logic [9:0] scan_row,
  output logic       out_valid,
  input  logic       out_ready,
  output code_t      out_data,
  output logic       busy_hold
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EVAL    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  localparam logic [2:0] CONF_N    = 3'(CONFIRM_N);
  localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT - 1);

  logic [1:0] state_r;
  logic       samp_en_r;
  code_t      samp_data_r;
  logic [1:0] row_idx_r;
  logic [3:0] miss_cnt_r;
  logic [2:0] match_cnt_r;
  code_t      cand_r;
  code_t      last_pub_r;
  logic       pub_lock_r;
  logic [9:0] scan_row_r;
  logic       out_valid_r;
  code_t      out_data_r;
  logic       busy_hold_r;

  logic       good_s;
  code_t      cand_nxt_s;
  logic [2:0] match_nxt_s;
  logic [3:0] miss_nxt_s;
  logic [1:0] row_idx_nxt_s;
  logic [9:0] row_sel_s;
  logic       publish_s;

`ifdef BARCODE_CKSUM_EN
  logic cksum_pass_s;

  ean13_cksum u_cksum (
    .code (samp_data_r),
    .pass (cksum_pass_s)
  );

  assign good_s = samp_en_r && digits_valid(samp_data_r) && cksum_pass_s;
`else
  assign good_s = samp_en_r && digits_valid(samp_data_r);
`endif

  // Evaluate one sample: next candidate, match/miss counters, row and publish decision.
  always_comb begin
    cand_nxt_s    = cand_r;
    match_nxt_s   = match_cnt_r;
    miss_nxt_s    = miss_cnt_r;
    row_idx_nxt_s = row_idx_r;
    if (good_s) begin
      miss_nxt_s = 4'd0;
      if (samp_data_r == cand_r) begin
        if (match_cnt_r >= CONF_N) begin
          match_nxt_s = CONF_N;
        end else begin
          match_nxt_s = match_cnt_r + 3'd1;
        end
      end else begin
        cand_nxt_s  = samp_data_r;
        match_nxt_s = 3'd1;
      end
    end else begin
      match_nxt_s = 3'd0;
      if (miss_cnt_r >= MISS_LAST) begin
        miss_nxt_s    = 4'd0;
        row_idx_nxt_s = row_idx_r + 2'd1;
      end else begin
        miss_nxt_s = miss_cnt_r + 4'd1;
      end
    end
    // A code already published stays suppressed until a bad frame releases the lock.
    publish_s = (match_nxt_s == CONF_N) && !(pub_lock_r && (cand_nxt_s == last_pub_r));
  end

  // Map the next row index onto its configured scan row.
  always_comb begin
    case (row_idx_nxt_s)
      2'd0:    row_sel_s = ROW0;
      2'd1:    row_sel_s = ROW1;
      2'd2:    row_sel_s = ROW2;
      2'd3:    row_sel_s = ROW3;
      default: row_sel_s = ROW0;
    endcase
  end

  // Frame sequencer: sample, evaluate, then hold the published code until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      samp_en_r   <= 1'b0;
      samp_data_r <= '0;
      row_idx_r   <= 2'd0;
      miss_cnt_r  <= 4'd0;
      match_cnt_r <= 3'd0;
      cand_r      <= '0;
      last_pub_r  <= '0;
      pub_lock_r  <= 1'b0;
      scan_row_r  <= ROW0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      busy_hold_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (frame_sync) begin
            samp_en_r   <= scan_en;
            samp_data_r <= scan_data;
            state_r     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          cand_r      <= cand_nxt_s;
          match_cnt_r <= match_nxt_s;
          miss_cnt_r  <= miss_nxt_s;
          row_idx_r   <= row_idx_nxt_s;
          scan_row_r  <= row_sel_s;
          if (!good_s) begin
            pub_lock_r <= 1'b0;
          end
          if (publish_s) begin
            out_data_r  <= cand_nxt_s;
            out_valid_r <= 1'b1;
            busy_hold_r <= 1'b1;
            last_pub_r  <= cand_nxt_s;
            pub_lock_r  <= 1'b1;
            state_r     <= ST_PUBLISH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PUBLISH: begin
          // frame_sync is deliberately ignored here, including on the transfer cycle.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_hold_r <= 1'b0;
            match_cnt_r <= 3'd0;
            state_r     <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign scan_row  = scan_row_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy_hold = busy_hold_r;

endmodule

// File: tb/tb_barcode_scan_ctrl.sv
// Scoreboard bench for barcode_scan_ctrl. Honors BARCODE_CKSUM_EN in its model.
module tb_barcode_scan_ctrl;

  localparam int MISS_LIMIT = 4;
  localparam int CONFIRM_N  = 3;

  typedef struct {
    logic [51:0] code;
    int          fcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_sync;
  logic        scan_en;
  logic [51:0] scan_data;
  logic [9:0]  scan_row;
  logic        out_valid;
  logic        out_ready;
  logic [51:0] out_data;
  logic        busy_hold;

  barcode_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_sync (frame_sync),
    .scan_en    (scan_en),
    .scan_data  (scan_data),
    .scan_row   (scan_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy_hold  (busy_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] rows [4] = '{10'd80, 10'd100, 10'd130, 10'd160};

  // Reference model state
  exp_t        exp_q [$];
  logic [51:0] m_cand;
  logic [51:0] m_last;
  int          m_run;
  int          m_miss;
  int          m_row;
  bit          m_lock;
  bit          m_pending;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Printed-order hex (first digit in the top nibble) to port packing (digit 0 in bits [3:0]).
  function automatic logic [51:0] mk(input logic [51:0] h);
    logic [51:0] c;
    for (int k = 0; k < 13; k++) c[4*k +: 4] = h[4*(12-k) +: 4];
    return c;
  endfunction

  function automatic bit model_good(input logic en, input logic [51:0] d);
    bit ok;
    int s;
    ok = en;
    s  = 0;
    for (int k = 0; k < 13; k++) begin
      if (d[4*k +: 4] > 4'd9) ok = 0;
      if (k == 12) s += int'(d[4*k +: 4]);
      else if (k % 2 == 1) s += 3 * int'(d[4*k +: 4]);
      else s += int'(d[4*k +: 4]);
    end
`ifdef BARCODE_CKSUM_EN
    if (s % 10 != 0) ok = 0;
`endif
    return ok;
  endfunction

  task automatic model_reset();
    m_cand = '0; m_last = '0; m_run = 0; m_miss = 0; m_row = 0;
    m_lock = 0; m_pending = 0;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic en, input logic [51:0] d, input int fc);
    if (!m_pending) begin
      if (model_good(en, d)) begin
        if (d == m_cand) m_run++;
        else begin
          m_cand = d;
          m_run  = 1;
        end
        m_miss = 0;
        if (m_run >= CONFIRM_N && !(m_lock && m_cand == m_last)) begin
          exp_q.push_back('{m_cand, fc});
          m_last    = m_cand;
          m_lock    = 1;
          m_pending = 1;
          m_run     = 0;
        end
      end else begin
        m_run  = 0;
        m_lock = 0;
        m_miss++;
        if (m_miss == MISS_LIMIT) begin
          m_miss = 0;
          m_row  = (m_row + 1) % 4;
        end
      end
    end
  endtask

  task automatic do_frame(input logic en, input logic [51:0] d, input logic rdy);
    @(negedge clk);
    out_ready  = rdy;
    frame_sync = 1'b1;
    scan_en    = en;
    scan_data  = d;
    model_frame(en, d, cyc);
    @(negedge clk);
    frame_sync = 1'b0;
    scan_en    = 1'($urandom);
    scan_data  = {20'($urandom), 32'($urandom)};
    repeat (6) @(negedge clk);
    if (rdy) m_pending = 0;
    check("scan_row", 64'(scan_row), 64'(rows[m_row]));
  endtask

  // Monitor: pop the expected code on each new publish, then require it stable while held.
  bit          prev_v = 0;
  logic [51:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 0;
    end else begin
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_publish", 64'(out_data), 64'd0);
          if (out_data == 52'd0) begin
            n_fail++;
            $display("FAIL unexpected_publish: got valid expected none (cycle %0d)", cyc);
          end
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pub_data", 64'(out_data), 64'(e.code));
          check("pub_latency", 64'(cyc - e.fcyc), 64'd2);
          check("busy_hold", 64'(busy_hold), 64'd1);
        end
        held = out_data;
      end else if (out_valid && prev_v) begin
        check("held_data", 64'(out_data), 64'(held));
      end
      prev_v = out_valid;
    end
  end

  initial begin
    logic [51:0] ca, cb, cc, cbad, cur, d;
    int pick;
    ca   = mk(52'h6901234567892);
    cb   = mk(52'h4006381333931);
    cc   = mk(52'h5012345678900);
    cbad = mk(52'h6901234567891);

    rst = 1'b1; frame_sync = 1'b0; scan_en = 1'b0; scan_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_scan_row", 64'(scan_row), 64'(rows[0]));
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy_hold", 64'(busy_hold), 64'd0);
    rst = 1'b0;

    // Confirm and publish once, hold off while present, republish after a gap.
    repeat (3) do_frame(1'b1, ca, 1'b1);
    check("digit0", 64'(ca[3:0]), 64'd6);
    repeat (10) do_frame(1'b1, ca, 1'b1);
    do_frame(1'b0, ca, 1'b1);
    repeat (3) do_frame(1'b1, ca, 1'b1);

    // Row rotation, and a good frame clearing the miss count.
    repeat (16) do_frame(1'b0, '0, 1'b1);
    repeat (2) do_frame(1'b0, '0, 1'b1);
    do_frame(1'b1, cb, 1'b1);
    repeat (3) do_frame(1'b0, '0, 1'b1);
    repeat (5) do_frame(1'b0, '0, 1'b1);

    // Alternating codes never confirm; then a steady run does.
    repeat (2) begin
      do_frame(1'b1, ca, 1'b1);
      do_frame(1'b1, cb, 1'b1);
    end
    repeat (3) do_frame(1'b1, ca, 1'b1);

    // Bad check digit.
    repeat (3) do_frame(1'b1, cbad, 1'b1);
    repeat (3) do_frame(1'b1, cbad, 1'b1);

    // Stall with frames arriving during PUBLISH, then reset mid-publish.
    repeat (3) do_frame(1'b1, cc, 1'b0);
    do_frame(1'b1, cb, 1'b0);
    do_frame(1'b0, '0, 1'b0);
    repeat (4) @(negedge clk);
    check("valid_held", 64'(out_valid), 64'(m_pending));
    rst = 1'b1;
    @(negedge clk);
    check("rst_drop_valid", 64'(out_valid), 64'd0);
    check("rst_drop_busy", 64'(busy_hold), 64'd0);
    check("rst_row", 64'(scan_row), 64'(rows[0]));
    rst = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) do_frame(1'b1, cc, 1'b1);

    // Randomized frames with sticky code choice and random back-pressure.
    cur = ca;
    for (int i = 0; i < 80; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 6) d = cur;
      else if (pick == 6) begin
        case ($urandom_range(0, 3))
          0: cur = ca;
          1: cur = cb;
          2: cur = cc;
          default: cur = cbad;
        endcase
        d = cur;
      end else if (pick == 7) d = {20'($urandom), 32'($urandom)};
      else d = cur;
      do_frame((pick == 8) ? 1'b0 : 1'b1, d, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
